// File: rtl/arm_alu_pkg.sv
// rtl/arm_alu_pkg.sv - shared opcodes, FSM states and NZCV bit positions for the ALU sequencer
package arm_alu_pkg;

  localparam logic [10:0] OP_ADD  = 11'h020;
  localparam logic [10:0] OP_ADDU = 11'h021;
  localparam logic [10:0] OP_SUB  = 11'h022;
  localparam logic [10:0] OP_SUBU = 11'h023;
  localparam logic [10:0] OP_AND  = 11'h024;
  localparam logic [10:0] OP_ORR  = 11'h025;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  function automatic logic op_legal(input logic [10:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_ORR: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/arm_alu_settle_cnt.sv
// rtl/arm_alu_settle_cnt.sv - 4-bit settle down-counter with load, decrement and done
module arm_alu_settle_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign done = (cnt == 4'd0);

endmodule

// File: rtl/arm_alu_sequencer.sv
// rtl/arm_alu_sequencer.sv - sequences one request at a time through an external ALU and returns result/NZCV
module arm_alu_sequencer
  import arm_alu_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [10:0] req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic        req_setflags,
  output logic [10:0] alu_op,
  output logic [63:0] alu_in0,
  output logic [63:0] alu_in1,
  input  logic [63:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_carryout,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic [3:0]  rsp_nzcv,
  output logic        rsp_err,
  output logic [3:0]  flags_nzcv
);

  // Counter runs SETTLE-1 down to 0, giving exactly SETTLE cycles in ISSUE.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic       setflags_q;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_done;
  logic       handshake;
  logic       req_legal;
  logic       op_logic;
  logic       op_no_v;
  logic [3:0] cap_nzcv;

  assign handshake = req_valid && req_ready;
  assign req_legal = op_legal(req_op);
  assign rsp_valid = (state == ST_RESP);

  arm_alu_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (handshake) begin
          state_nxt = req_legal ? ST_ISSUE : ST_RESP;
          cnt_load  = req_legal;
        end
      end
      ST_ISSUE: begin
        if (cnt_done) state_nxt = ST_CAPTURE;
        else          cnt_dec   = 1'b1;
      end
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // alu_op only ever holds a legal opcode, so it doubles as the in-flight op for masking.
  always_comb begin
    op_logic = (alu_op == OP_AND) || (alu_op == OP_ORR);
    op_no_v  = op_logic || (alu_op == OP_ADDU) || (alu_op == OP_SUBU);
    cap_nzcv = 4'd0;
    cap_nzcv[NZCV_N] = alu_out[63];
    cap_nzcv[NZCV_Z] = alu_zero;
    cap_nzcv[NZCV_C] = alu_carryout && !op_logic;
    cap_nzcv[NZCV_V] = alu_overflow && !op_no_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      setflags_q <= 1'b0;
      alu_op     <= 11'd0;
      alu_in0    <= 64'd0;
      alu_in1    <= 64'd0;
      rsp_result <= 64'd0;
      rsp_nzcv   <= 4'd0;
      rsp_err    <= 1'b0;
      flags_nzcv <= 4'd0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == ST_IDLE);
      if (state == ST_IDLE && handshake) begin
        setflags_q <= req_setflags;
        if (req_legal) begin
          alu_op  <= req_op;
          alu_in0 <= req_a;
          alu_in1 <= req_b;
          rsp_err <= 1'b0;
        end else begin
          rsp_result <= 64'd0;
          rsp_nzcv   <= 4'd0;
          rsp_err    <= 1'b1;
        end
      end
      if (state == ST_CAPTURE) begin
        rsp_result <= alu_out;
        rsp_nzcv   <= cap_nzcv;
        if (setflags_q) flags_nzcv <= cap_nzcv;
      end
    end
  end

endmodule

// File: tb/tb_arm_alu_sequencer.sv
// tb/tb_arm_alu_sequencer.sv - self-checking bench for arm_alu_sequencer with a behavioural ALU
module tb_arm_alu_sequencer;
  import arm_alu_pkg::*;

  localparam int SETTLE = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        req_setflags;
  logic [10:0] alu_op;
  logic [63:0] alu_in0;
  logic [63:0] alu_in1;
  logic [63:0] alu_out;
  logic        alu_zero;
  logic        alu_carryout;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_nzcv;
  logic        rsp_err;
  logic [3:0]  flags_nzcv;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_flags;

  arm_alu_sequencer #(.SETTLE(SETTLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_setflags (req_setflags),
    .alu_op       (alu_op),
    .alu_in0      (alu_in0),
    .alu_in1      (alu_in1),
    .alu_out      (alu_out),
    .alu_zero     (alu_zero),
    .alu_carryout (alu_carryout),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_nzcv     (rsp_nzcv),
    .rsp_err      (rsp_err),
    .flags_nzcv   (flags_nzcv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU; logic ops report C=V=1 so the sequencer's masking is exercised.
  always_comb begin
    alu_out      = 64'd0;
    alu_carryout = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      OP_ADD, OP_ADDU: begin
        alu_out      = alu_in0 + alu_in1;
        alu_carryout = (alu_out < alu_in0);
        alu_overflow = (alu_in0[63] == alu_in1[63]) && (alu_out[63] != alu_in0[63]);
      end
      OP_SUB, OP_SUBU: begin
        alu_out      = alu_in0 - alu_in1;
        alu_carryout = (alu_in0 >= alu_in1);
        alu_overflow = (alu_in0[63] != alu_in1[63]) && (alu_out[63] != alu_in0[63]);
      end
      OP_AND: begin
        alu_out = alu_in0 & alu_in1; alu_carryout = 1'b1; alu_overflow = 1'b1;
      end
      OP_ORR: begin
        alu_out = alu_in0 | alu_in1; alu_carryout = 1'b1; alu_overflow = 1'b1;
      end
      default: alu_out = 64'd0;
    endcase
  end
  assign alu_zero = (alu_out == 64'd0);

  // Reference: {err, result[63:0], nzcv[3:0]} from wide arithmetic.
  function automatic logic [68:0] model(input logic [10:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0]        u;
    logic signed [64:0] s;
    logic [63:0]        res;
    logic               c;
    logic               v;
    res = 64'd0; c = 1'b0; v = 1'b0;
    if (op == OP_ADD || op == OP_ADDU) begin
      u = {1'b0, a} + {1'b0, b};
      s = $signed({a[63], a}) + $signed({b[63], b});
      res = u[63:0]; c = u[64]; v = (s[64] != s[63]) && (op == OP_ADD);
    end else if (op == OP_SUB || op == OP_SUBU) begin
      u = {1'b0, a} - {1'b0, b};
      s = $signed({a[63], a}) - $signed({b[63], b});
      res = u[63:0]; c = ~u[64]; v = (s[64] != s[63]) && (op == OP_SUB);
    end else if (op == OP_AND) begin
      res = a & b;
    end else if (op == OP_ORR) begin
      res = a | b;
    end else begin
      return {1'b1, 64'd0, 4'd0};
    end
    return {1'b0, res, res[63], (res == 64'd0), c, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_check(input string name, input logic [10:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic sf, input int hold,
                           input logic [63:0] e_res, input logic [3:0] e_nzcv,
                           input logic e_err, input logic [3:0] e_flags);
    logic [10:0] op_before;
    int          lat;
    int          waited;
    bit          ok;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk); waited++;
    end
    chk({name, " ready"}, {63'd0, req_ready}, 64'd1);
    op_before = alu_op;
    req_op = op; req_a = a; req_b = b; req_setflags = sf; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_op = 11'($urandom);
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom}; req_setflags = 1'($urandom);
    lat = 1; ok = 1;
    while (!rsp_valid && lat < 40) begin
      if (alu_op != op || alu_in0 != a || alu_in1 != b || req_ready) ok = 0;
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk); lat++;
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk({name, " latency"}, 64'(lat), e_err ? 64'd1 : 64'(SETTLE + 2));
    if (e_err) chk({name, " alu_op kept"}, {53'd0, alu_op}, {53'd0, op_before});
    else       chk({name, " alu stable"}, {63'd0, ok}, 64'd1);
    chk({name, " result"}, rsp_result, e_res);
    chk({name, " nzcv"}, {60'd0, rsp_nzcv}, {60'd0, e_nzcv});
    chk({name, " err"}, {63'd0, rsp_err}, {63'd0, e_err});
    chk({name, " flags"}, {60'd0, flags_nzcv}, {60'd0, e_flags});
    if (hold > 0) begin
      ok = 1;
      req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_result != e_res || rsp_nzcv != e_nzcv || rsp_err != e_err || req_ready) ok = 0;
      end
      req_valid = 1'b0;
      chk({name, " held"}, {63'd0, ok}, 64'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, " released"}, {62'd0, rsp_valid, req_ready}, 64'd1);
  endtask

  typedef struct {
    logic [10:0] op;
    logic [63:0] a;
    logic [63:0] b;
    logic        sf;
    int          hold;
    logic [63:0] res;
    logic [3:0]  nzcv;
    logic        err;
    logic [3:0]  flags;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [68:0] m;
    logic [10:0] op;
    logic [63:0] a;
    logic [63:0] b;
    logic        sf;
    int          idx;
    int          bad;

    tbl[0] = '{OP_ADD,  64'h00000000f2340000, 64'h0000000080000000, 1'b1, 5, 64'h0000000172340000, 4'b0000, 1'b0, 4'b0000};
    tbl[1] = '{OP_ADD,  64'h7fffffffffffffff, 64'd1,                1'b1, 0, 64'h8000000000000000, 4'b1001, 1'b0, 4'b1001};
    tbl[2] = '{OP_ADDU, 64'hffffffffffffffff, 64'd1,                1'b0, 1, 64'd0,                4'b0110, 1'b0, 4'b1001};
    tbl[3] = '{11'h7ff, 64'h1234,             64'h5678,             1'b1, 2, 64'd0,                4'b0000, 1'b1, 4'b1001};
    tbl[4] = '{OP_SUB,  64'd5,                64'd7,                1'b1, 0, 64'hfffffffffffffffe, 4'b1000, 1'b0, 4'b1000};
    tbl[5] = '{OP_SUBU, 64'd3,                64'd3,                1'b1, 0, 64'd0,                4'b0110, 1'b0, 4'b0110};
    tbl[6] = '{OP_AND,  64'h8000000000000001, 64'hffffffffffffffff, 1'b0, 0, 64'h8000000000000001, 4'b1000, 1'b0, 4'b0110};
    tbl[7] = '{OP_ORR,  64'd0,                64'd0,                1'b1, 0, 64'd0,                4'b0100, 1'b0, 4'b0100};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    req_setflags = 1'b0; rsp_ready = 1'b0; exp_flags = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {62'd0, req_ready, rsp_valid}, 64'd0);
    chk("reset alu", {alu_op, alu_in0 | alu_in1}, '0);
    chk("reset rsp", {rsp_result | {55'd0, rsp_nzcv, rsp_err, flags_nzcv}}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after reset", {63'd0, req_ready}, 64'd1);

    for (int i = 0; i < 8; i++)
      run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sf, tbl[i].hold,
                tbl[i].res, tbl[i].nzcv, tbl[i].err, tbl[i].flags);

    // Reset in the middle of ISSUE with nonzero flags standing.
    req_op = OP_ADD; req_a = 64'd9; req_b = 64'd9; req_setflags = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midreset ctl", {62'd0, req_ready, rsp_valid}, 64'd0);
    chk("midreset alu", {alu_op, alu_in0 | alu_in1}, '0);
    chk("midreset rsp", {rsp_result | {55'd0, rsp_nzcv, rsp_err, flags_nzcv}}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_flags = 4'd0;
    bad = 0;
    for (int i = 0; i < 3 * SETTLE + 6; i++) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    chk("no aborted rsp", 64'(bad), 64'd0);
    run_check("post reset add", OP_ADD, 64'd5, 64'd6, 1'b1, 0, 64'd11, 4'b0000, 1'b0, 4'b0000);

    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 6);
      op = (idx < 6) ? (OP_ADD + 11'(idx)) : 11'($urandom_range(11'h026, 11'h7ff));
      case ($urandom_range(0, 3))
        0: a = 64'hffffffffffffffff;
        1: a = 64'h7fffffffffffffff;
        default: a = {$urandom, $urandom};
      endcase
      b = ($urandom_range(0, 3) == 0) ? 64'd1 : {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) b = a;
      sf = 1'($urandom);
      m = model(op, a, b);
      if (!m[68] && sf) exp_flags = m[3:0];
      run_check($sformatf("rand%0d", n), op, a, b, sf, $urandom_range(0, 2),
                m[67:4], m[3:0], m[68], exp_flags);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
